// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encodings, scancode constants, FIFO sizing.
package ps2_rx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_REL = 8'hF0;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = 3;

  // BAT-ok, ACK, echo and resend replies are not key events.
  function automatic logic is_nonkey(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) || (code == 8'hFE);
  endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// PS/2 line conditioning: 2-FF synchronisers, ps2_clk glitch filter, one-cycle fall pulse with
// the synchronised data bit captured in the same cycle. Reusable for a mouse receiver.
module ps2_rx_filter #(
  parameter int FILT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = $clog2(FILT + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;
  logic          data_q, data_d;

  // Filtered clock follows the synchronised level only after FILT consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILT - 1)) filt_d = clk_sync_q[1];
      else                        cnt_d  = cnt_q + CW'(1);
    end
    fall_d = filt_q & ~filt_d;
    data_d = fall_d ? data_sync_q[1] : data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
      data_q      <= data_d;
    end
  end

  assign fall_o = fall_q;
  assign data_o = data_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard host receiver: frame deserialiser, timeout, set-2 make/break/E0 decoder.
// Optional byte FIFO enabled with `define PS2_RX_FIFO_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (0) on a filtered fall
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
module ps2_kbd_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILT    = 4,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       byte_rd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended
);

  logic fall;
  logic sdata;

  ps2_rx_filter #(.FILT(FILT)) u_filter (
    .clk_i      (clk_sys),
    .rst_i      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .fall_o     (fall),
    .data_o     (sdata)
  );

  logic [1:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            good_q, good_d;
  logic [7:0]      gbyte_q, gbyte_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            terr_q, terr_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    to_d    = to_q;
    good_d  = 1'b0;
    gbyte_d = gbyte_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall && !sdata) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d[idx_q] = sdata;
          if (idx_q == 3'd7) state_d = ST_PARITY;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = sdata;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (!sdata)                    ferr_d = 1'b1;
          else if (~^{shift_q, par_q})   perr_d = 1'b1;
          else begin
            good_d  = 1'b1;
            gbyte_d = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fall always restarts the count, so it can never coincide with an abort.
    if (state_q == ST_IDLE) begin
      to_d = '0;
    end else if (fall) begin
      to_d = '0;
    end else if (to_q == TO_W'(TIMEOUT - 1)) begin
      to_d    = '0;
      state_d = ST_IDLE;
      terr_d  = 1'b1;
    end else begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      to_q    <= '0;
      good_q  <= 1'b0;
      gbyte_q <= 8'h00;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      to_q    <= to_d;
      good_q  <= good_d;
      gbyte_q <= gbyte_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      terr_q  <= terr_d;
    end
  end

  logic       ext_q, ext_d;
  logic       rel_q, rel_d;
  logic       ks_q, ks_d;
  logic [7:0] kc_q, kc_d;
  logic       kp_q, kp_d;
  logic       ke_q, ke_d;

  always_comb begin
    ext_d = ext_q;
    rel_d = rel_q;
    ks_d  = 1'b0;
    kc_d  = kc_q;
    kp_d  = kp_q;
    ke_d  = ke_q;
    if (good_q) begin
      if (gbyte_q == SC_EXT)      ext_d = 1'b1;
      else if (gbyte_q == SC_REL) rel_d = 1'b1;
      else if (!is_nonkey(gbyte_q)) begin
        ks_d  = 1'b1;
        kc_d  = gbyte_q;
        kp_d  = ~rel_q;
        ke_d  = ext_q;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
    if (perr_d || ferr_d || terr_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
      ks_q  <= 1'b0;
      kc_q  <= 8'h00;
      kp_q  <= 1'b0;
      ke_q  <= 1'b0;
    end else begin
      ext_q <= ext_d;
      rel_q <= rel_d;
      ks_q  <= ks_d;
      kc_q  <= kc_d;
      kp_q  <= kp_d;
      ke_q  <= ke_d;
    end
  end

  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign timeout_err  = terr_q;
  assign key_strobe   = ks_q;
  assign key_code     = kc_q;
  assign key_pressed  = kp_q;
  assign key_extended = ke_q;

`ifdef PS2_RX_FIFO_EN
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [FIFO_AW:0] wp_q, rp_q;
  logic             empty, full, pop, push;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                 (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign pop   = byte_rd & ~empty;
  // When full, a push is only accepted if the head leaves in the same cycle.
  assign push  = good_q & (~full | pop);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push) begin
        mem_q[wp_q[FIFO_AW-1:0]] <= gbyte_q;
        wp_q                     <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end

  assign byte_valid = ~empty;
  assign byte_data  = mem_q[rp_q[FIFO_AW-1:0]];
`else
  logic unused_byte_rd;
  assign unused_byte_rd = byte_rd;
  assign byte_valid     = good_q;
  assign byte_data      = gbyte_q;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: frames are bit-banged on ps2_clk/ps2_data, expected bytes,
// key events and error pulses are queued at send time and popped as the DUT reports them.
module tb_ps2_kbd_rx;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       byte_rd;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;

  ps2_kbd_rx dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .byte_rd      (byte_rd),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .timeout_err  (timeout_err),
    .key_strobe   (key_strobe),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int last_bv_cyc = -10;
  bit drain_en = 1'b1;

  logic [7:0] exp_byte_q[$];
  logic [9:0] exp_key_q[$];
  int         exp_err_q[$];

  localparam int E_PAR = 1;
  localparam int E_FRM = 2;
  localparam int E_TO  = 3;

  always @(posedge clk_sys) cyc++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic see_err(input int kind);
    if (exp_err_q.size() == 0) check_val("err_unexpected", kind, 0);
    else                       check_val("err_kind", kind, exp_err_q.pop_front());
  endtask

  // Output monitor / scoreboard, evaluated on the inactive edge.
  initial begin
    byte_rd = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
`ifdef PS2_RX_FIFO_EN
        if (drain_en && byte_valid) begin
          if (exp_byte_q.size() == 0) check_val("byte_unexpected", byte_data, 32'h100);
          else                        check_val("byte_data", byte_data, exp_byte_q.pop_front());
          byte_rd = 1'b1;
        end else begin
          byte_rd = 1'b0;
        end
`else
        if (byte_valid) begin
          if (exp_byte_q.size() == 0) check_val("byte_unexpected", byte_data, 32'h100);
          else                        check_val("byte_data", byte_data, exp_byte_q.pop_front());
          last_bv_cyc = cyc;
        end
`endif
        if (key_strobe) begin
          if (exp_key_q.size() == 0)
            check_val("key_unexpected", {key_code, key_pressed, key_extended}, 32'h400);
          else
            check_val("key_event", {key_code, key_pressed, key_extended}, exp_key_q.pop_front());
`ifndef PS2_RX_FIFO_EN
          check_val("key_latency", cyc - last_bv_cyc, 1);
`endif
        end
        if (parity_err)  see_err(E_PAR);
        if (frame_err)   see_err(E_FRM);
        if (timeout_err) see_err(E_TO);
      end else begin
        byte_rd = 1'b0;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Device changes data mid-high, then drives a 100-low / 100-high clock (200-cycle period).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(100);
      ps2_clk = 1'b0;
      wait_clk(100);
      ps2_clk = 1'b1;
    end
    wait_clk(50);
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_byte_q.push_back(b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic exp_key(input logic [7:0] code, input bit pressed, input bit ext);
    exp_key_q.push_back({code, pressed, ext});
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_byte_valid"}, byte_valid, 0);
    check_val({tag, "_byte_data"}, byte_data, 0);
    check_val({tag, "_errs"}, {parity_err, frame_err, timeout_err}, 0);
    check_val({tag, "_key"}, {key_strobe, key_code, key_pressed, key_extended}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    check_idle_outputs("reset");
    reset = 1'b0;
    wait_clk(20);

    // Single make code
    exp_key(8'h1C, 1'b1, 1'b0);
    send_good(8'h1C);

    // Extended release
    exp_key(8'h75, 1'b0, 1'b1);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);

    // Parity error clears a pending E0
    send_good(8'hE0);
    exp_err_q.push_back(E_PAR);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    exp_key(8'h1C, 1'b0, 1'b0);
    send_good(8'hF0);
    send_good(8'h1C);

    // Stop bit 0, then timeout clears a pending E0
    exp_err_q.push_back(E_FRM);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    send_good(8'hE0);
    exp_err_q.push_back(E_TO);
    send_frame(8'h55, 1'b0, 1'b0, 4);
    wait_clk(4300);
    exp_key(8'h6B, 1'b1, 1'b0);
    send_good(8'h6B);

    // Non-key reply byte keeps the E0 prefix
    exp_key(8'h1C, 1'b1, 1'b1);
    send_good(8'hE0);
    send_good(8'hAA);
    send_good(8'h1C);

    // Short ps2_clk glitches while idle
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      wait_clk(2);
      ps2_clk = 1'b1;
      wait_clk(20);
    end
    exp_key(8'h2D, 1'b1, 1'b0);
    send_good(8'h2D);

    // Reset in the middle of a frame drops the partial byte and the E0 prefix
    send_good(8'hE0);
    wait_clk(100);
    send_frame(8'h55, 1'b0, 1'b0, 5);
    reset = 1'b1;
    wait_clk(3);
    check_idle_outputs("midreset");
    reset = 1'b0;
    wait_clk(20);
    exp_key(8'h1C, 1'b1, 1'b0);
    send_good(8'h1C);

`ifdef PS2_RX_FIFO_EN
    // Fill past depth with no reads: ninth byte is lost, key events still fire.
    wait_clk(20);
    drain_en = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      exp_key(8'(b), 1'b1, 1'b0);
      if (b <= 8) exp_byte_q.push_back(8'(b));
      send_frame(8'(b), 1'b0, 1'b0, 11);
    end
    wait_clk(20);
    check_val("fifo_full_valid", byte_valid, 1);
    check_val("fifo_head", byte_data, 8'h01);
    drain_en = 1'b1;
    wait_clk(40);
    check_val("fifo_empty_valid", byte_valid, 0);
`endif

    wait_clk(300);
    check_val("bytes_left", exp_byte_q.size(), 0);
    check_val("keys_left", exp_key_q.size(), 0);
    check_val("errs_left", exp_err_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
